// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state encoding, control-word bit indices.
// The jump decode in controlador_sequenciador is enabled by defining SAP1_JUMP_EN.
package sap1_pkg;

    // Opcodes as held in IR[7:4]
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int T_W = 6;

    // One-hot ring states; HALT is the all-zero pattern so T reads 0 while frozen
    typedef enum logic [T_W-1:0] {
        ST_HALT = 6'b000000,
        ST_T1   = 6'b000001,
        ST_T2   = 6'b000010,
        ST_T3   = 6'b000100,
        ST_T4   = 6'b001000,
        ST_T5   = 6'b010000,
        ST_T6   = 6'b100000
    } t_state_e;

    // Bit positions inside the internal control word
    typedef enum int unsigned {
        CW_CP  = 0,
        CW_EP  = 1,
        CW_EJ  = 2,
        CW_LM  = 3,
        CW_CE  = 4,
        CW_LI  = 5,
        CW_EI  = 6,
        CW_LA  = 7,
        CW_EA  = 8,
        CW_SU  = 9,
        CW_EU  = 10,
        CW_LB  = 11,
        CW_LO  = 12,
        CW_HLT = 13
    } cw_idx_e;

    localparam int CW_W = 14;

endpackage

// File: rtl/controlador_sequenciador_contador_anel.sv
// contador_anel: 6-state one-hot ring counter T1..T6 with a terminal HALT state.
// CLR is synchronous active-low and overrides everything, including HALT.
module contador_anel
    import sap1_pkg::*;
(
    input  logic           CLK,
    input  logic           CLR,
    input  logic           halt_i,
    output logic [T_W-1:0] T
);

    t_state_e state_q, state_d;

    // State register; reset lands directly in T1 so fetch starts on the next cycle
    always_ff @(posedge CLK) begin
        if (!CLR) state_q <= ST_T1;
        else      state_q <= state_d;
    end

    // Ring advance; a halt request is only honoured while in T4
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = halt_i ? ST_HALT : ST_T5;
            ST_T5:   state_d = ST_T6;
            ST_T6:   state_d = ST_T1;
            ST_HALT: state_d = ST_HALT;
            // Any corrupted (non one-hot) pattern restarts fetch
            default: state_d = ST_T1;
        endcase
    end

    assign T = state_q;

endmodule

// File: rtl/controlador_sequenciador.sv
// controlador_sequenciador: SAP-1 controller-sequencer. Decodes the control word
// combinationally from the ring T-state and the IR opcode nibble.
// Define SAP1_JUMP_EN to decode 0011 as JMP; otherwise 0011 is a NOP and Ej stays 0.
module controlador_sequenciador
    import sap1_pkg::*;
(
    input  logic           CLK,
    input  logic           CLR,
    input  logic [3:0]     Opcode,
    output logic [T_W-1:0] T,
    output logic           Cp,
    output logic           Ep,
    output logic           Ej,
    output logic           Lm,
    output logic           Ce,
    output logic           Li,
    output logic           Ei,
    output logic           La,
    output logic           Ea,
    output logic           Su,
    output logic           Eu,
    output logic           Lb,
    output logic           Lo,
    output logic           Hlt
);

    logic            halt_req;
    logic [CW_W-1:0] cw;

    // HLT leaves T4 straight into HALT instead of T5
    assign halt_req = (T == ST_T4) && (Opcode == OP_HLT);

    contador_anel u_anel (
        .CLK    (CLK),
        .CLR    (CLR),
        .halt_i (halt_req),
        .T      (T)
    );

    // Control-word decode: fetch is opcode-independent, execute depends on Opcode
    always_comb begin
        cw = '0;
        case (T)
            ST_HALT: cw[CW_HLT] = 1'b1;
            ST_T1: begin
                cw[CW_EP] = 1'b1;
                cw[CW_LM] = 1'b1;
            end
            ST_T2: cw[CW_CP] = 1'b1;
            ST_T3: begin
                cw[CW_CE] = 1'b1;
                cw[CW_LI] = 1'b1;
            end
            ST_T4: begin
                case (Opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_EI] = 1'b1;
                        cw[CW_LM] = 1'b1;
                    end
`ifdef SAP1_JUMP_EN
                    OP_JMP: begin
                        cw[CW_EI] = 1'b1;
                        cw[CW_EJ] = 1'b1;
                    end
`endif
                    OP_OUT: begin
                        cw[CW_EA] = 1'b1;
                        cw[CW_LO] = 1'b1;
                    end
                    OP_HLT:  cw[CW_HLT] = 1'b1;
                    default: cw = '0;
                endcase
            end
            ST_T5: begin
                case (Opcode)
                    OP_LDA: begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LB] = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            ST_T6: begin
                case (Opcode)
                    OP_ADD: begin
                        cw[CW_EU] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end
                    OP_SUB: begin
                        cw[CW_EU] = 1'b1;
                        cw[CW_LA] = 1'b1;
                        cw[CW_SU] = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            default: cw = '0;
        endcase
    end

    assign Cp  = cw[CW_CP];
    assign Ep  = cw[CW_EP];
    // Without the jump feature nothing ever sets this bit, so Ej is constant 0
    assign Ej  = cw[CW_EJ];
    assign Lm  = cw[CW_LM];
    assign Ce  = cw[CW_CE];
    assign Li  = cw[CW_LI];
    assign Ei  = cw[CW_EI];
    assign La  = cw[CW_LA];
    assign Ea  = cw[CW_EA];
    assign Su  = cw[CW_SU];
    assign Eu  = cw[CW_EU];
    assign Lb  = cw[CW_LB];
    assign Lo  = cw[CW_LO];
    assign Hlt = cw[CW_HLT];

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Self-checking bench for controlador_sequenciador: directed steps then random
// opcodes/resets, compared against a phase-counter model of the instruction table.
module tb_controlador_sequenciador;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] Opcode = 4'h0;
    logic [5:0] T;
    logic Cp, Ep, Ej, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt;

    int total = 0;
    int bad   = 0;

    // Model state: phase 0..5 = T1..T6, plus halted flag
    int phase   = 0;
    bit halted  = 1'b0;
    bit known   = 1'b0;

    controlador_sequenciador dut (
        .CLK(CLK), .CLR(CLR), .Opcode(Opcode), .T(T),
        .Cp(Cp), .Ep(Ep), .Ej(Ej), .Lm(Lm), .Ce(Ce), .Li(Li), .Ei(Ei),
        .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .Hlt(Hlt)
    );

    always #5 CLK = ~CLK;

    // Expected outputs packed as {Cp,Ep,Ej,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo,Hlt}
    function automatic logic [13:0] model_cw(input int ph, input bit hl, input logic [3:0] op);
        bit cp = 0, ep = 0, ej = 0, lm = 0, ce = 0, li = 0, ei = 0;
        bit la = 0, ea = 0, su = 0, eu = 0, lb = 0, lo = 0, h = 0;
        if (hl) h = 1;
        else begin
            case (ph)
                0: begin ep = 1; lm = 1; end
                1: cp = 1;
                2: begin ce = 1; li = 1; end
                3: begin
                    if (op == 4'd0 || op == 4'd1 || op == 4'd2) begin ei = 1; lm = 1; end
`ifdef SAP1_JUMP_EN
                    if (op == 4'd3) begin ei = 1; ej = 1; end
`endif
                    if (op == 4'd14) begin ea = 1; lo = 1; end
                    if (op == 4'd15) h = 1;
                end
                4: begin
                    if (op == 4'd0) begin ce = 1; la = 1; end
                    if (op == 4'd1 || op == 4'd2) begin ce = 1; lb = 1; end
                end
                5: begin
                    if (op == 4'd1 || op == 4'd2) begin eu = 1; la = 1; end
                    if (op == 4'd2) su = 1;
                end
                default: ;
            endcase
        end
        return {cp, ep, ej, lm, ce, li, ei, la, ea, su, eu, lb, lo, h};
    endfunction

    // One clock: drive inputs, check at negedge, advance model at posedge
    task automatic step(input bit clr, input logic [3:0] op);
        logic [13:0] obs, expv;
        logic [5:0]  exp_t;
        CLR = clr;
        Opcode = op;
        @(negedge CLK);
        if (known) begin
            obs   = {Cp, Ep, Ej, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt};
            expv  = model_cw(phase, halted, op);
            exp_t = halted ? 6'b0 : (6'b1 << phase);
            total++;
            assert (T === exp_t) else begin
                bad++;
                $error("FAIL tstate ph=%0d op=%h obs=%b exp=%b", phase, op, T, exp_t);
            end
            total++;
            assert (obs === expv) else begin
                bad++;
                $error("FAIL ctrl ph=%0d halt=%0d op=%h obs=%b exp=%b", phase, halted, op, obs, expv);
            end
            total++;
            assert (($countones({Ep, Ce, Ei, Ea, Eu}) <= 1) === 1'b1) else begin
                bad++;
                $error("FAIL busdrv obs=%b exp=at-most-one", {Ep, Ce, Ei, Ea, Eu});
            end
            total++;
            assert ((Cp & Ej) === 1'b0) else begin
                bad++;
                $error("FAIL cp_ej obs=%b exp=0", Cp & Ej);
            end
        end
        @(posedge CLK);
        if (!clr) begin
            phase = 0; halted = 0; known = 1;
        end else if (known && !halted) begin
            if (phase == 3 && op == 4'hF) halted = 1;
            else phase = (phase + 1) % 6;
        end
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) step(1'b1, op);
    endtask

    initial begin
        // Reset, then the reset state itself is checked on the first instruction step
        step(1'b0, 4'h0);
        run_instr(4'h0);    // LDA, back to T1 afterwards
        run_instr(4'h1);    // ADD
        run_instr(4'h2);    // SUB
        run_instr(4'h3);    // JMP or NOP depending on build
        run_instr(4'hE);    // OUT
        run_instr(4'h5);    // undefined -> NOP
        // Opcode garbage during fetch must be ignored
        step(1'b1, 4'hF); step(1'b1, 4'hF); step(1'b1, 4'hF);
        step(1'b1, 4'h1); step(1'b1, 4'h1); step(1'b1, 4'h1);
        // Abort in T5
        for (int i = 0; i < 4; i++) step(1'b1, 4'h0);
        step(1'b0, 4'h0);
        run_instr(4'h1);
        // HLT then stay frozen for 20 cycles, then reset
        for (int i = 0; i < 4; i++) step(1'b1, 4'hF);
        for (int i = 0; i < 20; i++) step(1'b1, 4'($urandom_range(0, 15)));
        step(1'b0, 4'hF);
        run_instr(4'h2);
        // Random opcodes with occasional reset
        for (int i = 0; i < 800; i++)
            step(($urandom_range(0, 39) != 0), 4'($urandom_range(0, 15)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
